// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmit path.
// Frame states, parity modes and data-field length clamping.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_mode_t;

    localparam int MIN_DATA_BITS = 5;

    // Encoding 2'b11 is reserved and behaves as no parity.
    function automatic parity_mode_t decode_parity(input logic [1:0] p);
        parity_mode_t m;
        case (p)
            2'b01:   m = PAR_EVEN;
            2'b10:   m = PAR_ODD;
            default: m = PAR_NONE;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] clamp_bits(
        input logic [3:0] req,
        input logic [3:0] max_bits
    );
        logic [3:0] n;
        if (req < 4'(MIN_DATA_BITS))
            n = 4'(MIN_DATA_BITS);
        else if (req > max_bits)
            n = max_bits;
        else
            n = req;
        return n;
    endfunction

endpackage

// File: rtl/baud_from_osr.sv
// Divides oversample ticks down to one baud tick every OSR ticks.
// Counter is held cleared while disabled so each frame starts on a fresh period.
module baud_from_osr #(
    parameter int OSR = 16
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    input  logic osr_tick_i,
    output logic baud_tick_o
);

    localparam int CW = $clog2(OSR + 1);
    localparam logic [CW-1:0] LAST = CW'(OSR - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i || !en_i)
            cnt_q <= '0;
        else if (osr_tick_i)
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    assign baud_tick_o = en_i && osr_tick_i && (cnt_q == LAST);

endmodule

// File: rtl/tx_engine_cfg.sv
// Runtime-configurable UART transmitter: FIFO word in, one framed
// character out per word with snapshotted length/parity/stop/order.
module tx_engine_cfg
    import uart_pkg::*;
#(
    parameter int OSR           = 16,
    parameter int MAX_DATA_BITS = 9
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     osr_tick_i,
    input  logic                     tx_fifo_empty_i,
    input  logic                     tx_fifo_valid_i,
    input  logic [MAX_DATA_BITS-1:0] tx_fifo_data_i,
    output logic                     tx_fifo_ren_o,
    input  logic                     tx_en_i,
    input  logic [3:0]               data_bits_i,
    input  logic [1:0]               parity_i,
    input  logic                     stop2_i,
    input  logic                     msb_first_i,
    output logic                     tx_busy_o,
    output logic                     frame_done_o,
    output logic                     transmit_bit_o
);

    localparam int MW = MAX_DATA_BITS;

    tx_state_t        state_q, state_d;
    logic [MW-1:0]    shift_q, shift_d;
    logic [3:0]       nbits_q, nbits_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             par_en_q, par_en_d;
    logic             par_bit_q, par_bit_d;
    logic             stop2_q, stop2_d;
    logic             ren_q, ren_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             line_q, line_d;

    logic             capture;
    logic             baud_en;
    logic             baud_tick;
    logic [3:0]       req_nbits;
    logic [MW-1:0]    fld;
    logic [MW-1:0]    fld_full_rev;
    logic [MW-1:0]    fld_rev;
    parity_mode_t     pmode;

    // A valid seen while the read strobe is still out belongs to no request.
    assign capture = (state_q == FETCH) && tx_fifo_valid_i && !ren_q;
    assign baud_en = capture
                  || (state_q == START)
                  || (state_q == DATA)
                  || (state_q == PARITY)
                  || (state_q == STOP);

    baud_from_osr #(
        .OSR(OSR)
    ) u_baud (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .en_i       (baud_en),
        .osr_tick_i (osr_tick_i),
        .baud_tick_o(baud_tick)
    );

    // Mask unused high bits; MSB-first words are pre-reversed so the
    // shifter always emits from bit 0.
    always_comb begin
        req_nbits    = clamp_bits(data_bits_i, 4'(MW));
        pmode        = decode_parity(parity_i);
        fld          = tx_fifo_data_i & ~({MW{1'b1}} << req_nbits);
        fld_full_rev = '0;
        for (int i = 0; i < MW; i++)
            fld_full_rev[i] = fld[MW-1-i];
        fld_rev      = fld_full_rev >> (4'(MW) - req_nbits);
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        nbits_d   = nbits_q;
        cnt_d     = cnt_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;
        ren_d     = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        line_d    = line_q;
        unique case (state_q)
            IDLE: begin
                if (tx_en_i && !tx_fifo_empty_i) begin
                    state_d = FETCH;
                    ren_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            FETCH: begin
                if (capture) begin
                    shift_d   = msb_first_i ? fld_rev : fld;
                    nbits_d   = req_nbits;
                    par_en_d  = (pmode != PAR_NONE);
                    par_bit_d = (^fld) ^ (pmode == PAR_ODD);
                    stop2_d   = stop2_i;
                    cnt_d     = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    line_d  = 1'b0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    line_d  = shift_q[0];
                    shift_d = shift_q >> 1;
                    if (cnt_q == nbits_q - 4'd1) begin
                        cnt_d   = '0;
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    line_d  = par_bit_q;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    line_d = 1'b1;
                    if (cnt_q == (stop2_q ? 4'd2 : 4'd1)) begin
                        cnt_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                line_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            nbits_q   <= 4'(MIN_DATA_BITS);
            cnt_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            ren_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            line_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            nbits_q   <= nbits_d;
            cnt_q     <= cnt_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            ren_q     <= ren_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            line_q    <= line_d;
        end
    end

    assign tx_fifo_ren_o  = ren_q;
    assign tx_busy_o      = busy_q;
    assign frame_done_o   = done_q;
    assign transmit_bit_o = line_q;

endmodule

// File: tb/tb_tx_engine_cfg.sv
// Directed bench for tx_engine_cfg: frames are sampled mid-bit and
// compared against hand-built bit vectors (index 0 = first bit on the line).
module tb_tx_engine_cfg;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       osr_tick = 1'b0;
    logic       fifo_empty = 1'b1;
    logic       fifo_valid = 1'b0;
    logic [8:0] fifo_data = '0;
    logic       fifo_ren;
    logic       tx_en = 1'b0;
    logic [3:0] data_bits = 4'd8;
    logic [1:0] parity = 2'b00;
    logic       stop2 = 1'b0;
    logic       msb_first = 1'b0;
    logic       busy;
    logic       frame_done;
    logic       tx_line;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ren_cnt = 0;
    int done_cnt = 0;
    logic ren_seen = 1'b0;
    logic [8:0] fifo_q[$];

    tx_engine_cfg #(
        .OSR(16),
        .MAX_DATA_BITS(9)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .osr_tick_i     (osr_tick),
        .tx_fifo_empty_i(fifo_empty),
        .tx_fifo_valid_i(fifo_valid),
        .tx_fifo_data_i (fifo_data),
        .tx_fifo_ren_o  (fifo_ren),
        .tx_en_i        (tx_en),
        .data_bits_i    (data_bits),
        .parity_i       (parity),
        .stop2_i        (stop2),
        .msb_first_i    (msb_first),
        .tx_busy_o      (busy),
        .frame_done_o   (frame_done),
        .transmit_bit_o (tx_line)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Oversample tick every other clock: one baud period = 32 clocks.
    always @(negedge clk) osr_tick = ~osr_tick;

    // FIFO model: read data returns one cycle after the strobe is seen.
    always @(negedge clk) begin
        fifo_valid = 1'b0;
        if (ren_seen && fifo_q.size() > 0) begin
            fifo_data  = fifo_q.pop_front();
            fifo_valid = 1'b1;
        end
        ren_seen = fifo_ren;
        if (fifo_ren === 1'b1) ren_cnt++;
        if (frame_done === 1'b1) done_cnt++;
        fifo_empty = (fifo_q.size() == 0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_frame(input string tag, input logic [15:0] bits,
                               input int n);
        int t0;
        bit seen;
        seen = 0;
        for (int k = 0; k < 4000 && !seen; k++) begin
            @(negedge clk);
            if (tx_line === 1'b0) seen = 1;
        end
        chk({tag, " start"}, 32'(seen), 32'd1);
        if (seen) begin
            t0 = cyc;
            repeat (16) @(negedge clk);
            for (int i = 0; i < n; i++) begin
                chk($sformatf("%s bit%0d", tag, i), 32'(tx_line), 32'(bits[i]));
                if (i == n - 1) chk({tag, " busy_last"}, 32'(busy), 32'd1);
                else repeat (32) @(negedge clk);
            end
            seen = 0;
            for (int k = 0; k < 64 && !seen; k++) begin
                if (frame_done === 1'b1) seen = 1;
                else @(negedge clk);
            end
            chk({tag, " done"}, 32'(seen), 32'd1);
            chk({tag, " length"}, 32'(cyc - t0), 32'(n * 32));
            chk({tag, " busy_after"}, 32'(busy), 32'd0);
        end
    endtask

    task automatic set_cfg(input logic [3:0] nb, input logic [1:0] par,
                           input logic s2, input logic msb);
        data_bits = nb;
        parity    = par;
        stop2     = s2;
        msb_first = msb;
    endtask

    initial begin
        int r0;
        int d0;
        bit seen;

        repeat (3) @(negedge clk);
        chk("reset line", 32'(tx_line), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset ren", 32'(fifo_ren), 32'd0);
        chk("reset done", 32'(frame_done), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 8N1 LSB first, 0xA5
        set_cfg(4'd8, 2'b00, 1'b0, 1'b0);
        tx_en = 1'b1;
        r0 = ren_cnt;
        d0 = done_cnt;
        fifo_q.push_back(9'h0A5);
        check_frame("8N1_A5", {1'b1, 8'hA5, 1'b0}, 10);
        @(negedge clk);
        chk("8N1_A5 ren_pulses", 32'(ren_cnt - r0), 32'd1);
        chk("8N1_A5 done_pulses", 32'(done_cnt - d0), 32'd1);

        // 7E2, 0x35: four ones -> even parity 0
        set_cfg(4'd7, 2'b01, 1'b1, 1'b0);
        fifo_q.push_back(9'h035);
        check_frame("7E2_35", {2'b11, 1'b0, 7'h35, 1'b0}, 11);

        // 9O1, 0x1FF: nine ones -> odd parity 0
        set_cfg(4'd9, 2'b10, 1'b0, 1'b0);
        fifo_q.push_back(9'h1FF);
        check_frame("9O1_1FF", {1'b1, 1'b0, 9'h1FF, 1'b0}, 12);

        // Requested length 3 clamps to 5; upper word bits ignored
        set_cfg(4'd3, 2'b00, 1'b0, 1'b0);
        fifo_q.push_back(9'h0FF);
        check_frame("5N1_FF", {1'b1, 5'h1F, 1'b0}, 7);

        // Requested length 15 clamps to 9; reserved parity acts as none
        set_cfg(4'd15, 2'b11, 1'b0, 1'b0);
        fifo_q.push_back(9'h155);
        check_frame("9N1_155", {1'b1, 9'h155, 1'b0}, 11);

        // MSB first
        set_cfg(4'd8, 2'b00, 1'b0, 1'b1);
        fifo_q.push_back(9'h081);
        check_frame("MSB_81", {1'b1, 8'h81, 1'b0}, 10);
        fifo_q.push_back(9'h001);
        check_frame("MSB_01", {1'b1, 8'h80, 1'b0}, 10);

        // Two words back to back
        set_cfg(4'd8, 2'b00, 1'b0, 1'b0);
        fifo_q.push_back(9'h055);
        fifo_q.push_back(9'h00F);
        check_frame("B2B_55", {1'b1, 8'h55, 1'b0}, 10);
        @(negedge clk);
        chk("B2B fetch_ren", 32'(fifo_ren), 32'd1);
        chk("B2B fetch_busy", 32'(busy), 32'd1);
        check_frame("B2B_0F", {1'b1, 8'h0F, 1'b0}, 10);

        // Config changed mid-frame: 8E1 frame stays, next frame is 5O2
        set_cfg(4'd8, 2'b01, 1'b0, 1'b0);
        fifo_q.push_back(9'h003);
        fork
            check_frame("CFG_8E1", {1'b1, 1'b0, 8'h03, 1'b0}, 11);
            begin
                repeat (100) @(negedge clk);
                set_cfg(4'd5, 2'b10, 1'b1, 1'b0);
            end
        join
        fifo_q.push_back(9'h003);
        check_frame("CFG_5O2", {2'b11, 1'b1, 5'h03, 1'b0}, 9);

        // tx_en dropped mid-frame
        set_cfg(4'd8, 2'b00, 1'b0, 1'b0);
        r0 = ren_cnt;
        fifo_q.push_back(9'h000);
        fifo_q.push_back(9'h0FF);
        fork
            check_frame("EN_00", {1'b1, 8'h00, 1'b0}, 10);
            begin
                repeat (100) @(negedge clk);
                tx_en = 1'b0;
            end
        join
        repeat (200) @(negedge clk);
        chk("EN idle_busy", 32'(busy), 32'd0);
        chk("EN idle_line", 32'(tx_line), 32'd1);
        chk("EN ren_pulses", 32'(ren_cnt - r0), 32'd1);
        chk("EN fifo_left", 32'(fifo_q.size()), 32'd1);

        // Reset in the middle of the data field
        tx_en = 1'b1;
        seen = 0;
        for (int k = 0; k < 4000 && !seen; k++) begin
            @(negedge clk);
            if (tx_line === 1'b0) seen = 1;
        end
        chk("RST start", 32'(seen), 32'd1);
        repeat (3 * 32 + 16) @(negedge clk);
        chk("RST pre_busy", 32'(busy), 32'd1);
        d0 = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        chk("RST line", 32'(tx_line), 32'd1);
        chk("RST busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (400) @(negedge clk);
        chk("RST no_done", 32'(done_cnt - d0), 32'd0);
        chk("RST idle_line", 32'(tx_line), 32'd1);

        fifo_q.push_back(9'h03C);
        check_frame("POST_3C", {1'b1, 8'h3C, 1'b0}, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
